// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-port 32-bit data memory behind a valid/ready request
//                handshake with a programmable wait latency.
//                A request accepted in IDLE is latched, followed by a
//                one-cycle mem_ready_out pulse. The block then waits LATENCY
//                cycles, performs the access, and issues a one-cycle
//                mem_valid_out pulse. Writes honour byte-lane enables. Reads,
//                and writes alike, return the word as it was before the
//                access (read-before-write).
//  Ports       : clk              - clock, rising edge
//                rst              - synchronous active-low reset
//                mem_valid_in     - request valid
//                mem_read_en_in   - request is a read
//                mem_write_en_in  - request is a write (wins if both set)
//                mem_addr_in      - byte address
//                mem_wdata_in     - write data
//                mem_byte_en_in   - write byte-lane enables
//                mem_ready_out    - request-accepted pulse
//                mem_valid_out    - response-valid pulse
//                mem_rdata_out    - response data, held until next response
//  Options     : DATA_MEM_RANGE_CHECK_EN - when defined, accesses with
//                addr[31:2] >= DEPTH_WORDS leave storage untouched and
//                return 32'hDEADBEEF. When undefined, the address wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [3:0]  mem_byte_en_in,
    output logic        mem_ready_out,
    output logic        mem_valid_out,
    output logic [31:0] mem_rdata_out
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_latency = 4'(LATENCY);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_accept;
    logic          w_access;

    // Request captured at acceptance; inputs are ignored afterwards.
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_we;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [31:0]   w_resp_word;
    logic          w_wr_en;

    // Byte-offset bits never select anything; upper bits only matter for
    // the optional range check.
    logic          w_unused_addr_bits;
    assign w_unused_addr_bits = ^{mem_addr_in[1:0], mem_addr_in[31:AW+2]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_valid_in && (mem_read_en_in || mem_write_en_in)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_nxt   = c_latency;
                end
            end
            c_ST_WAIT: begin
                // The cycle the counter is found at zero is the access cycle,
                // so LATENCY=0 accesses on the first WAIT cycle.
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and handshake registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= 4'd0;
            mem_ready_out <= 1'b0;
            mem_valid_out <= 1'b0;
            mem_rdata_out <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            mem_ready_out <= w_accept;
            mem_valid_out <= w_access;
            if (w_access) begin
                mem_rdata_out <= w_resp_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= mem_addr_in[AW+1:2];
            r_wdata <= mem_wdata_in;
            r_be    <= mem_byte_en_in;
            r_we    <= mem_write_en_in;
        end
    end

    // ------------------------------------------------------------------
    // Response word and write enable
    // ------------------------------------------------------------------
`ifdef DATA_MEM_RANGE_CHECK_EN
    logic r_oob;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_oob <= |mem_addr_in[31:AW+2];
        end
    end

    assign w_resp_word = r_oob ? 32'hDEAD_BEEF : r_mem[r_idx];
    assign w_wr_en     = w_access && r_we && !r_oob;
`else
    assign w_resp_word = r_mem[r_idx];
    assign w_wr_en     = w_access && r_we;
`endif

    // ------------------------------------------------------------------
    // Storage: not reset. The write is gated by rst so an access that
    // coincides with reset is abandoned.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//                u_dut runs with LATENCY=2, u_dut0 with LATENCY=0 for the
//                held-request throughput case.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready, vld;
    logic [31:0] rdata;

    logic        valid0, rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ready0, vld0;
    logic [31:0] rdata0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_in    (valid),
        .mem_read_en_in  (rd),
        .mem_write_en_in (wr),
        .mem_addr_in     (addr),
        .mem_wdata_in    (wdata),
        .mem_byte_en_in  (be),
        .mem_ready_out   (ready),
        .mem_valid_out   (vld),
        .mem_rdata_out   (rdata)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_in    (valid0),
        .mem_read_en_in  (rd0),
        .mem_write_en_in (wr0),
        .mem_addr_in     (addr0),
        .mem_wdata_in    (wdata0),
        .mem_byte_en_in  (be0),
        .mem_ready_out   (ready0),
        .mem_valid_out   (vld0),
        .mem_rdata_out   (rdata0)
    );

    // Drives one request for a single edge, then scrambles the request
    // inputs and records when the pulses appeared over a 10-cycle window.
    // Cycle k is the cycle following acceptance edge k-1.
    task automatic issue(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output int rdy_cyc, output int rdy_cnt,
                         output int vld_cyc, output int vld_cnt,
                         output logic [31:0] resp);
        rdy_cyc = -1; rdy_cnt = 0; vld_cyc = -1; vld_cnt = 0; resp = 32'hx;
        @(negedge clk);
        valid = 1'b1; wr = w; rd = r; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1;
        valid = 1'b0; wr = ~w; rd = ~r; addr = ~a; wdata = ~d; be = ~b;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready) begin rdy_cyc = c; rdy_cnt++; end
            if (vld)   begin vld_cyc = c; vld_cnt++; resp = rdata; end
        end
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid = 0; rd = 0; wr = 0; addr = 0; wdata = 0; be = 0;
        valid0 = 0; rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", vld); end
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int rc, rn, vc, vn; logic [31:0] rs;
        issue(1, 0, 32'h10, 32'h1234_5678, 4'hF, rc, rn, vc, vn, rs);
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL wr_ready_cycle got %0d exp 1", rc); end
        n_vec++; if (rn !== 1) begin n_err++; $display("FAIL wr_ready_count got %0d exp 1", rn); end
        n_vec++; if (vc !== 4) begin n_err++; $display("FAIL wr_valid_cycle got %0d exp 4", vc); end
        n_vec++; if (vn !== 1) begin n_err++; $display("FAIL wr_valid_count got %0d exp 1", vn); end
        issue(0, 1, 32'h10, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data got %h exp 12345678", rs); end
        n_vec++; if (vc !== 4) begin n_err++; $display("FAIL rd_valid_cycle got %0d exp 4", vc); end
        n_vec++; if (rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rdata_hold got %h exp 12345678", rdata); end
    endtask

    task automatic test_byte_lanes();
        int rc, rn, vc, vn; logic [31:0] rs;
        issue(1, 0, 32'h10, 32'hAABB_CCDD, 4'b0101, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h1234_5678) begin n_err++; $display("FAIL be_wr_resp got %h exp 12345678", rs); end
        issue(0, 1, 32'h10, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h12BB_56DD) begin n_err++; $display("FAIL be_rd got %h exp 12bb56dd", rs); end
        // Empty byte mask: handshake completes, storage untouched.
        issue(1, 0, 32'h10, 32'hFFFF_FFFF, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (vn !== 1 || rn !== 1) begin n_err++; $display("FAIL be0_handshake got rdy %0d vld %0d exp 1 1", rn, vn); end
        // Low address bits ignored.
        issue(0, 1, 32'h13, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h12BB_56DD) begin n_err++; $display("FAIL be0_rd got %h exp 12bb56dd", rs); end
        // Both enables: write with read-before-write response.
        issue(1, 1, 32'h10, 32'h0102_0304, 4'hF, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h12BB_56DD) begin n_err++; $display("FAIL both_resp got %h exp 12bb56dd", rs); end
        issue(0, 1, 32'h10, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h0102_0304) begin n_err++; $display("FAIL both_rd got %h exp 01020304", rs); end
    endtask

    task automatic test_reset_mid();
        int rc, rn, vc, vn, cnt; logic [31:0] rs;
        issue(1, 0, 32'h20, 32'h1111_1111, 4'hF, rc, rn, vc, vn, rs);
        issue(0, 1, 32'h20, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        cnt = 0;
        @(negedge clk);
        valid = 1; wr = 1; rd = 0; addr = 32'h20; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge clk);
        #1 valid = 0; wr = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (vld) cnt++;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL midrst_rdata got %h exp 0", rdata); end
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (vld) cnt++;
        end
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL midrst_valid got %0d pulses exp 0", cnt); end
        issue(0, 1, 32'h20, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h1111_1111) begin n_err++; $display("FAIL midrst_rd got %h exp 11111111", rs); end
    endtask

    task automatic test_range();
        int rc, rn, vc, vn; logic [31:0] rs;
        issue(1, 0, 32'h0, 32'hCAFE_0000, 4'hF, rc, rn, vc, vn, rs);
        issue(1, 0, 32'h1000, 32'h0000_0055, 4'hF, rc, rn, vc, vn, rs);
        n_vec++; if (vc !== 4) begin n_err++; $display("FAIL range_valid_cycle got %0d exp 4", vc); end
`ifdef DATA_MEM_RANGE_CHECK_EN
        n_vec++; if (rs !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL range_resp got %h exp deadbeef", rs); end
        issue(0, 1, 32'h0, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'hCAFE_0000) begin n_err++; $display("FAIL range_rd0 got %h exp cafe0000", rs); end
`else
        n_vec++; if (rs !== 32'hCAFE_0000) begin n_err++; $display("FAIL wrap_resp got %h exp cafe0000", rs); end
        issue(0, 1, 32'h0, 32'h0, 4'h0, rc, rn, vc, vn, rs);
        n_vec++; if (rs !== 32'h0000_0055) begin n_err++; $display("FAIL wrap_rd0 got %h exp 00000055", rs); end
`endif
    endtask

    task automatic test_no_enable();
        int rn, vn;
        rn = 0; vn = 0;
        @(negedge clk);
        valid = 1; rd = 0; wr = 0; addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready) rn++;
            if (vld) vn++;
        end
        valid = 0;
        n_vec++; if (rn !== 0) begin n_err++; $display("FAIL noen_ready got %0d pulses exp 0", rn); end
        n_vec++; if (vn !== 0) begin n_err++; $display("FAIL noen_valid got %0d pulses exp 0", vn); end
    endtask

    // LATENCY=0, request held: ready in cycles 1,4,7,10 and valid in 2,5,8,11.
    task automatic test_back_to_back();
        logic er, ev;
        @(negedge clk);
        valid0 = 1; rd0 = 1; addr0 = 32'h4;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            er = (c % 3) == 1;
            ev = (c % 3) == 2;
            n_vec++; if (ready0 !== er) begin n_err++; $display("FAIL b2b_ready cyc %0d got %b exp %b", c, ready0, er); end
            n_vec++; if (vld0 !== ev) begin n_err++; $display("FAIL b2b_valid cyc %0d got %b exp %b", c, vld0, ev); end
        end
        valid0 = 0; rd0 = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_reset_mid();
        test_range();
        test_no_enable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
